// File: rtl/fabric_output_arbiter.sv
// ---------------------------------------------------------------------------
// fabric_output_arbiter
//
// Shares one egress port's output FIFO push interface between NUM_PORTS
// ingress requesters. Grants are issued round-robin, only while the output
// buffer reports room for a maximum-size frame, and a grant covers exactly
// one whole frame. Frame words pass through a single register stage, and a
// minimum idle gap is inserted after every frame so the downstream VLAN
// tagger can flush a tagged frame's tail word before the next frame begins.
//
// Ports:
//   fabric_clk        - clock for all logic
//   rst_n             - asynchronous active-low reset
//   req               - [NUM_PORTS] requester i has a frame queued
//   grant             - [NUM_PORTS] one-hot (or zero) bus ownership
//   in_valid          - [NUM_PORTS] per-requester word valid
//   in_data           - [NUM_PORTS*64] per-requester data, slice i = [64*i+63:64*i]
//   in_bytes_valid    - [NUM_PORTS*4] valid bytes in the word (1..8)
//   in_vlan           - [NUM_PORTS*12] VLAN ID of the frame
//   in_ethertype      - [NUM_PORTS*16] ethertype of the frame
//   fabric_ready      - buffer has room for a maximum-size frame
//   out_valid         - forwarded word valid
//   out_data          - [64] forwarded data (0 when out_valid is low)
//   out_bytes_valid   - [4] forwarded byte count (0 when out_valid is low)
//   out_vlan          - [12] forwarded VLAN ID (0 when out_valid is low)
//   out_ethertype     - [16] forwarded ethertype (0 when out_valid is low)
//   timeout_pulse     - one-cycle strobe when a grant is revoked for timeout
//   frames_forwarded  - [32] count of completed frames, wraps at 2^32
// ---------------------------------------------------------------------------
module fabric_output_arbiter #(
   parameter int NUM_PORTS     = 4,
   parameter int GAP_CYCLES    = 2,
   parameter int GRANT_TIMEOUT = 64
) (
   input  logic                    fabric_clk,
   input  logic                    rst_n,
   input  logic [NUM_PORTS-1:0]    req,
   output logic [NUM_PORTS-1:0]    grant,
   input  logic [NUM_PORTS-1:0]    in_valid,
   input  logic [NUM_PORTS*64-1:0] in_data,
   input  logic [NUM_PORTS*4-1:0]  in_bytes_valid,
   input  logic [NUM_PORTS*12-1:0] in_vlan,
   input  logic [NUM_PORTS*16-1:0] in_ethertype,
   input  logic                    fabric_ready,
   output logic                    out_valid,
   output logic [63:0]             out_data,
   output logic [3:0]              out_bytes_valid,
   output logic [11:0]             out_vlan,
   output logic [15:0]             out_ethertype,
   output logic                    timeout_pulse,
   output logic [31:0]             frames_forwarded
);

   localparam int IW = $clog2(NUM_PORTS);
   localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      GRANTED,
      ACTIVE,
      GAP
   } state_t;

   state_t                 r_state;
   logic [NUM_PORTS-1:0]   r_grant;
   logic [IW-1:0]          r_gidx;
   logic [IW-1:0]          r_rr_ptr;
   logic [TW-1:0]          r_timer;
   logic [GW-1:0]          r_gap;
   logic                   r_out_valid;
   logic [63:0]            r_out_data;
   logic [3:0]             r_out_bytes;
   logic [11:0]            r_out_vlan;
   logic [15:0]            r_out_etype;
   logic                   r_timeout;
   logic [31:0]            r_frames;

   state_t                 w_state;
   logic [NUM_PORTS-1:0]   w_grant;
   logic [IW-1:0]          w_gidx;
   logic [IW-1:0]          w_rr_ptr;
   logic [TW-1:0]          w_timer;
   logic [GW-1:0]          w_gap;
   logic                   w_out_valid;
   logic [63:0]            w_out_data;
   logic [3:0]             w_out_bytes;
   logic [11:0]            w_out_vlan;
   logic [15:0]            w_out_etype;
   logic                   w_timeout;
   logic [31:0]            w_frames;

   logic                   w_pick_found;
   logic [IW-1:0]          w_pick_idx;
   logic                   w_sel_valid;
   logic                   w_sel_req;
   logic [63:0]            w_sel_data;
   logic [3:0]             w_sel_bytes;
   logic [11:0]            w_sel_vlan;
   logic [15:0]            w_sel_etype;

   // Round-robin pick: scan requesters starting at the pointer and wrap, so
   // the port served last becomes the lowest priority for the next decision.
   always_comb begin : rr_pick
      int idx;
      idx          = 0;
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
         end
         if (!w_pick_found && req[idx]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = IW'(idx);
         end
      end
   end

   // Only the granted requester's lanes are ever looked at; every other
   // port's inputs, including its in_valid, are invisible to the FSM.
   always_comb begin
      w_sel_valid = in_valid[r_gidx];
      w_sel_req   = req[r_gidx];
      w_sel_data  = in_data[64*int'(r_gidx) +: 64];
      w_sel_bytes = in_bytes_valid[4*int'(r_gidx) +: 4];
      w_sel_vlan  = in_vlan[12*int'(r_gidx) +: 12];
      w_sel_etype = in_ethertype[16*int'(r_gidx) +: 16];
   end

   // Next-state and next-output logic. Output data defaults to zero so the
   // bus is quiet whenever out_valid is low; everything else holds.
   always_comb begin
      w_state     = r_state;
      w_grant     = r_grant;
      w_gidx      = r_gidx;
      w_rr_ptr    = r_rr_ptr;
      w_timer     = r_timer;
      w_gap       = r_gap;
      w_frames    = r_frames;
      w_out_valid = 1'b0;
      w_out_data  = '0;
      w_out_bytes = '0;
      w_out_vlan  = '0;
      w_out_etype = '0;
      w_timeout   = 1'b0;

      case (r_state)
         IDLE: begin
            if (fabric_ready && w_pick_found) begin
               w_grant             = '0;
               w_grant[w_pick_idx] = 1'b1;
               w_gidx              = w_pick_idx;
               w_rr_ptr            = (w_pick_idx == IW'(NUM_PORTS-1)) ? '0 : w_pick_idx + 1'b1;
               w_timer             = '0;
               w_state             = GRANTED;
            end
         end

         GRANTED: begin
            if (w_sel_valid) begin
               w_out_valid = 1'b1;
               w_out_data  = w_sel_data;
               w_out_bytes = w_sel_bytes;
               w_out_vlan  = w_sel_vlan;
               w_out_etype = w_sel_etype;
               w_state     = ACTIVE;
            end else if (!w_sel_req) begin
               w_grant = '0;
               w_gap   = '0;
               w_state = GAP;
            end else if (r_timer == TW'(GRANT_TIMEOUT-1)) begin
               w_grant   = '0;
               w_timeout = 1'b1;
               w_gap     = '0;
               w_state   = GAP;
            end else begin
               w_timer = r_timer + 1'b1;
            end
         end

         ACTIVE: begin
            // A frame is never cut: req and fabric_ready are not consulted.
            if (w_sel_valid) begin
               w_out_valid = 1'b1;
               w_out_data  = w_sel_data;
               w_out_bytes = w_sel_bytes;
               w_out_vlan  = w_sel_vlan;
               w_out_etype = w_sel_etype;
            end else begin
               w_grant  = '0;
               w_frames = r_frames + 32'd1;
               w_gap    = '0;
               w_state  = GAP;
            end
         end

         GAP: begin
            // The first GAP cycle is the first out_valid-low cycle.
            if (r_gap == GW'(GAP_CYCLES-1)) begin
               w_state = IDLE;
            end else begin
               w_gap = r_gap + 1'b1;
            end
         end

         default: begin
            w_grant = '0;
            w_state = IDLE;
         end
      endcase
   end

   // State register. Reset is asynchronous so a mid-frame reset drops
   // out_valid and grant immediately without waiting for a clock edge.
   always_ff @(posedge fabric_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_gidx      <= '0;
         r_rr_ptr    <= '0;
         r_timer     <= '0;
         r_gap       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_bytes <= '0;
         r_out_vlan  <= '0;
         r_out_etype <= '0;
         r_timeout   <= 1'b0;
         r_frames    <= '0;
      end else begin
         r_state     <= w_state;
         r_grant     <= w_grant;
         r_gidx      <= w_gidx;
         r_rr_ptr    <= w_rr_ptr;
         r_timer     <= w_timer;
         r_gap       <= w_gap;
         r_out_valid <= w_out_valid;
         r_out_data  <= w_out_data;
         r_out_bytes <= w_out_bytes;
         r_out_vlan  <= w_out_vlan;
         r_out_etype <= w_out_etype;
         r_timeout   <= w_timeout;
         r_frames    <= w_frames;
      end
   end

   assign grant            = r_grant;
   assign out_valid        = r_out_valid;
   assign out_data         = r_out_data;
   assign out_bytes_valid  = r_out_bytes;
   assign out_vlan         = r_out_vlan;
   assign out_ethertype    = r_out_etype;
   assign timeout_pulse    = r_timeout;
   assign frames_forwarded = r_frames;

endmodule

// File: tb/tb_fabric_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fabric_output_arbiter
//
// Directed bench for fabric_output_arbiter with the default parameters
// (4 ports, 2-cycle gap, 64-cycle grant timeout). Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fabric_output_arbiter;

   localparam int NP   = 4;
   localparam int GAPC = 2;
   localparam int TO   = 64;

   logic             fabric_clk = 1'b0;
   logic             rst_n;
   logic [NP-1:0]    req;
   logic [NP-1:0]    grant;
   logic [NP-1:0]    in_valid;
   logic [NP*64-1:0] in_data;
   logic [NP*4-1:0]  in_bytes_valid;
   logic [NP*12-1:0] in_vlan;
   logic [NP*16-1:0] in_ethertype;
   logic             fabric_ready;
   logic             out_valid;
   logic [63:0]      out_data;
   logic [3:0]       out_bytes_valid;
   logic [11:0]      out_vlan;
   logic [15:0]      out_ethertype;
   logic             timeout_pulse;
   logic [31:0]      frames_forwarded;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   fabric_output_arbiter #(
      .NUM_PORTS     (NP),
      .GAP_CYCLES    (GAPC),
      .GRANT_TIMEOUT (TO)
   ) dut (
      .fabric_clk       (fabric_clk),
      .rst_n            (rst_n),
      .req              (req),
      .grant            (grant),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_bytes_valid   (in_bytes_valid),
      .in_vlan          (in_vlan),
      .in_ethertype     (in_ethertype),
      .fabric_ready     (fabric_ready),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_bytes_valid  (out_bytes_valid),
      .out_vlan         (out_vlan),
      .out_ethertype    (out_ethertype),
      .timeout_pulse    (timeout_pulse),
      .frames_forwarded (frames_forwarded)
   );

   // Free-running 10-unit clock.
   always #5 fabric_clk = ~fabric_clk;

   // Advance one clock and land just after the rising edge.
   task automatic tick;
      @(posedge fabric_clk);
      #1;
      cyc++;
   endtask

   task automatic drive_word(input int p, input logic [63:0] d, input logic [3:0] b,
                             input logic [11:0] v, input logic [15:0] e);
      in_valid[p]              = 1'b1;
      in_data[64*p +: 64]      = d;
      in_bytes_valid[4*p +: 4] = b;
      in_vlan[12*p +: 12]      = v;
      in_ethertype[16*p +: 16] = e;
   endtask

   task automatic idle_port(input int p);
      in_valid[p]              = 1'b0;
      in_data[64*p +: 64]      = '0;
      in_bytes_valid[4*p +: 4] = '0;
      in_vlan[12*p +: 12]      = '0;
      in_ethertype[16*p +: 16] = '0;
   endtask

   task automatic do_reset;
      rst_n          = 1'b0;
      req            = '0;
      in_valid       = '0;
      in_data        = '0;
      in_bytes_valid = '0;
      in_vlan        = '0;
      in_ethertype   = '0;
      fabric_ready   = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   // Everything cleared by reset, and no grant appears without a request.
   task automatic test_reset;
      do_reset;
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_grant: got %b expected 0000", grant);
      end
      checks++;
      if ({out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype} !== 97'd0) begin
         errors++;
         $display("[TB] FAIL reset_out: got %h expected 0",
                  {out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype});
      end
      checks++;
      if ({timeout_pulse, frames_forwarded} !== 33'd0) begin
         errors++;
         $display("[TB] FAIL reset_counters: got %h expected 0", {timeout_pulse, frames_forwarded});
      end
      fabric_ready = 1'b1;
      repeat (3) tick;
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_noreq_grant: got %b expected 0000", grant);
      end
   endtask

   // Port 1 sends three words (8,8,5 bytes).
   task automatic test_single_frame;
      logic [63:0] d [3];
      logic [3:0]  b [3];
      d[0] = 64'h1111_0000_0000_0001;
      d[1] = 64'h1111_0000_0000_0002;
      d[2] = 64'h1111_0000_0000_0003;
      b[0] = 4'd8;
      b[1] = 4'd8;
      b[2] = 4'd5;
      do_reset;
      fabric_ready = 1'b1;
      req          = 4'b0010;
      tick;
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL single_grant: got %b expected 0010", grant);
      end
      for (int w = 0; w < 3; w++) begin
         drive_word(1, d[w], b[w], 12'h064, 16'h0800);
         tick;
         checks++;
         if ({out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype} !==
             {1'b1, d[w], b[w], 12'h064, 16'h0800}) begin
            errors++;
            $display("[TB] FAIL single_word%0d: got %h expected %h", w,
                     {out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype},
                     {1'b1, d[w], b[w], 12'h064, 16'h0800});
         end
         checks++;
         if (grant !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_grant_hold%0d: got %b expected 0010", w, grant);
         end
      end
      idle_port(1);
      req = '0;
      tick;
      checks++;
      if ({out_valid, grant} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL single_end_valid_grant: got %b expected 00000", {out_valid, grant});
      end
      checks++;
      if ({out_data, out_bytes_valid, out_vlan, out_ethertype} !== 96'd0) begin
         errors++;
         $display("[TB] FAIL single_end_zero_bus: got %h expected 0",
                  {out_data, out_bytes_valid, out_vlan, out_ethertype});
      end
      checks++;
      if (frames_forwarded !== 32'd1) begin
         errors++;
         $display("[TB] FAIL single_frames: got %0d expected 1", frames_forwarded);
      end
      repeat (4) tick;
   endtask

   // All ports request; 1-word frames; strict rotation and minimum spacing.
   task automatic test_round_robin;
      int last = -1;
      do_reset;
      fabric_ready = 1'b1;
      req          = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         int p;
         int n;
         logic [NP-1:0] exp_g;
         logic [63:0]   d;
         p     = f % NP;
         n     = 0;
         exp_g = '0;
         exp_g[p] = 1'b1;
         d     = 64'hC0DE_0000_0000_0000 + 64'(f);
         while (grant == 4'b0000 && n < 20) begin
            tick;
            n++;
         end
         checks++;
         if (grant !== exp_g) begin
            errors++;
            $display("[TB] FAIL rr_grant%0d: got %b expected %b", f, grant, exp_g);
         end
         drive_word(p, d, 4'd8, 12'(p + 1), 16'h88B5);
         tick;
         checks++;
         if ({out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype} !==
             {1'b1, d, 4'd8, 12'(p + 1), 16'h88B5}) begin
            errors++;
            $display("[TB] FAIL rr_word%0d: got %h expected %h", f,
                     {out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype},
                     {1'b1, d, 4'd8, 12'(p + 1), 16'h88B5});
         end
         if (last >= 0) begin
            checks++;
            if (cyc - last - 1 < GAPC + 2) begin
               errors++;
               $display("[TB] FAIL rr_gap%0d: got %0d low cycles expected >= %0d", f,
                        cyc - last - 1, GAPC + 2);
            end
         end
         last = cyc;
         idle_port(p);
         tick;
      end
      req = '0;
      repeat (4) tick;
   endtask

   // No grant while the buffer is full; ready dropping mid-frame is ignored.
   task automatic test_flow_control;
      int hits = 0;
      do_reset;
      fabric_ready = 1'b0;
      req          = 4'b0001;
      repeat (100) begin
         tick;
         if (grant !== 4'b0000) hits++;
      end
      checks++;
      if (hits != 0) begin
         errors++;
         $display("[TB] FAIL fc_blocked: got %0d granted cycles expected 0", hits);
      end
      fabric_ready = 1'b1;
      tick;
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL fc_grant: got %b expected 0001", grant);
      end
      for (int w = 0; w < 3; w++) begin
         drive_word(0, 64'hF00D_0000_0000_0000 + 64'(w), 4'd8, 12'h00C, 16'h0806);
         tick;
         if (w == 0) fabric_ready = 1'b0;
         checks++;
         if ({out_valid, out_data} !== {1'b1, 64'hF00D_0000_0000_0000 + 64'(w)}) begin
            errors++;
            $display("[TB] FAIL fc_word%0d: got %h expected %h", w, {out_valid, out_data},
                     {1'b1, 64'hF00D_0000_0000_0000 + 64'(w)});
         end
      end
      idle_port(0);
      req = '0;
      tick;
      checks++;
      if ({frames_forwarded, grant} !== {32'd1, 4'b0000}) begin
         errors++;
         $display("[TB] FAIL fc_end: got frames %0d grant %b expected 1 and 0000",
                  frames_forwarded, grant);
      end
      repeat (4) tick;
   endtask

   // Port 2 granted but silent: timeout after 64 cycles, then port 3 next.
   task automatic test_timeout;
      int pulses   = 0;
      int pulse_at = -1;
      do_reset;
      fabric_ready = 1'b1;
      req          = 4'b1100;
      tick;
      checks++;
      if (grant !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL to_grant: got %b expected 0100", grant);
      end
      for (int k = 1; k <= 66; k++) begin
         tick;
         if (timeout_pulse === 1'b1) begin
            pulses++;
            pulse_at = k;
         end
         if (k == 63) begin
            checks++;
            if (grant !== 4'b0100) begin
               errors++;
               $display("[TB] FAIL to_grant_held: got %b expected 0100", grant);
            end
         end
         if (k == 64) begin
            checks++;
            if (grant !== 4'b0000) begin
               errors++;
               $display("[TB] FAIL to_grant_cleared: got %b expected 0000", grant);
            end
         end
      end
      checks++;
      if (pulses != 1 || pulse_at != TO) begin
         errors++;
         $display("[TB] FAIL to_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, pulse_at, TO);
      end
      checks++;
      if (frames_forwarded !== 32'd0) begin
         errors++;
         $display("[TB] FAIL to_frames: got %0d expected 0", frames_forwarded);
      end
      tick;
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL to_next_grant: got %b expected 1000", grant);
      end
      req = '0;
      repeat (5) tick;
   endtask

   // Non-granted in_valid is ignored; dropping req before valid aborts quietly.
   task automatic test_isolation_abort;
      int pulses = 0;
      do_reset;
      fabric_ready = 1'b1;
      req          = 4'b0001;
      tick;
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL iso_grant: got %b expected 0001", grant);
      end
      drive_word(1, 64'hBAD0_BAD0_BAD0_BAD0, 4'd7, 12'hFFF, 16'hDEAD);
      tick;
      checks++;
      if ({out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype} !== 97'd0) begin
         errors++;
         $display("[TB] FAIL iso_foreign_valid: got %h expected 0",
                  {out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype});
      end
      for (int w = 0; w < 3; w++) begin
         drive_word(0, 64'h0A0A_0000_0000_0000 + 64'(w), 4'd8, 12'h00A, 16'h86DD);
         in_valid[1] = (w % 2 == 1);
         tick;
         checks++;
         if ({out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype} !==
             {1'b1, 64'h0A0A_0000_0000_0000 + 64'(w), 4'd8, 12'h00A, 16'h86DD}) begin
            errors++;
            $display("[TB] FAIL iso_word%0d: got %h expected %h", w,
                     {out_valid, out_data, out_bytes_valid, out_vlan, out_ethertype},
                     {1'b1, 64'h0A0A_0000_0000_0000 + 64'(w), 4'd8, 12'h00A, 16'h86DD});
         end
      end
      idle_port(0);
      in_valid[1] = 1'b1;
      req = '0;
      tick;
      checks++;
      if ({out_valid, grant, frames_forwarded} !== {1'b0, 4'b0000, 32'd1}) begin
         errors++;
         $display("[TB] FAIL iso_end: got %h expected %h", {out_valid, grant, frames_forwarded},
                  {1'b0, 4'b0000, 32'd1});
      end
      idle_port(1);
      repeat (3) tick;
      req = 4'b0010;
      tick;
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL abort_grant: got %b expected 0010", grant);
      end
      req = '0;
      tick;
      checks++;
      if ({grant, timeout_pulse} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL abort_release: got %b expected 00000", {grant, timeout_pulse});
      end
      repeat (6) begin
         tick;
         if (timeout_pulse === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || frames_forwarded !== 32'd1) begin
         errors++;
         $display("[TB] FAIL abort_quiet: got %0d pulses frames %0d expected 0 and 1",
                  pulses, frames_forwarded);
      end
   endtask

   // Asynchronous reset during a frame clears immediately; pointer restarts at 0.
   task automatic test_reset_mid_frame;
      do_reset;
      fabric_ready = 1'b1;
      req          = 4'b0001;
      tick;
      drive_word(0, 64'h5555_0000_0000_0001, 4'd8, 12'h005, 16'h0800);
      tick;
      idle_port(0);
      req = '0;
      tick;
      checks++;
      if (frames_forwarded !== 32'd1) begin
         errors++;
         $display("[TB] FAIL rst_first_frame: got %0d expected 1", frames_forwarded);
      end
      repeat (3) tick;
      req = 4'b0010;
      tick;
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL rst_second_grant: got %b expected 0010", grant);
      end
      drive_word(1, 64'h6666_0000_0000_0001, 4'd8, 12'h006, 16'h0800);
      tick;
      drive_word(1, 64'h6666_0000_0000_0002, 4'd8, 12'h006, 16'h0800);
      tick;
      checks++;
      if ({out_valid, out_data} !== {1'b1, 64'h6666_0000_0000_0002}) begin
         errors++;
         $display("[TB] FAIL rst_word2: got %h expected %h", {out_valid, out_data},
                  {1'b1, 64'h6666_0000_0000_0002});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, grant, frames_forwarded, out_data} !== 101'd0) begin
         errors++;
         $display("[TB] FAIL rst_async_clear: got %h expected 0",
                  {out_valid, grant, frames_forwarded, out_data});
      end
      idle_port(1);
      req = 4'b1111;
      #2;
      rst_n = 1'b1;
      tick;
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL rst_next_grant: got %b expected 0001", grant);
      end
      req = '0;
      repeat (3) tick;
   endtask

   initial begin
      rst_n          = 1'b0;
      req            = '0;
      in_valid       = '0;
      in_data        = '0;
      in_bytes_valid = '0;
      in_vlan        = '0;
      in_ethertype   = '0;
      fabric_ready   = 1'b0;
      $display("[TB] starting fabric_output_arbiter tests");
      test_reset;
      test_single_frame;
      test_round_robin;
      test_flow_control;
      test_timeout;
      test_isolation_abort;
      test_reset_mid_frame;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
